// File: rtl/uart_cmd_receiver_if.sv
// Command bundle from the UART receive stage to the decoder/transmitter.
// master drives op/data and the one-cycle strobes.
interface uart_cmd_receiver_if;
  logic [7:0]  op;
  logic [31:0] data;
  logic        execute;
  logic        xon;
  logic        xoff;
  logic        id;
  logic        frame_err;

  modport master (
    output op, data, execute, xon, xoff, id, frame_err
  );

  modport slave (
    input op, data, execute, xon, xoff, id, frame_err
  );
endinterface

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver with short/long command assembly.
// Emits execute plus xon/xoff/id pulses for the host link.
module uart_cmd_receiver #(
  parameter int FREQ  = 100000000,
  parameter int RATE  = 115200,
  parameter int CNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic trxClock,
  input  logic rx,
  uart_cmd_receiver_if.master cmd
);

  localparam int BITLENGTH = FREQ / RATE;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BITLENGTH);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BITLENGTH / 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       rx_meta, rxs;
  logic       byte_ok, stop_bad;

  logic [2:0]  byte_idx;
  logic [7:0]  hold_op;
  logic [23:0] arg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // An event fires on the tick that brings the counter to its target.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (trxClock) begin
          if (cnt_inc == HALF) begin
            cnt_d = '0;
            bit_d = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DATA: begin
        if (trxClock) begin
          if (cnt_inc == FULL) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      STOP: begin
        if (trxClock) begin
          if (cnt_inc == FULL) begin
            cnt_d = '0;
            if (rxs) begin
              byte_ok = 1'b1;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd.op        <= '0;
      cmd.data      <= '0;
      cmd.execute   <= 1'b0;
      cmd.xon       <= 1'b0;
      cmd.xoff      <= 1'b0;
      cmd.id        <= 1'b0;
      cmd.frame_err <= 1'b0;
      byte_idx      <= '0;
      hold_op       <= '0;
      arg           <= '0;
    end else begin
      cmd.execute   <= 1'b0;
      cmd.xon       <= 1'b0;
      cmd.xoff      <= 1'b0;
      cmd.id        <= 1'b0;
      cmd.frame_err <= stop_bad;
      if (stop_bad) begin
        byte_idx <= '0;
      end else if (byte_ok) begin
        unique case (byte_idx)
          3'd0: begin
            if (!shift_q[7]) begin
              cmd.op      <= shift_q;
              cmd.data    <= '0;
              cmd.execute <= 1'b1;
              cmd.xon     <= (shift_q == 8'h11);
              cmd.xoff    <= (shift_q == 8'h13);
              cmd.id      <= (shift_q == 8'h02);
            end else begin
              hold_op  <= shift_q;
              byte_idx <= 3'd1;
            end
          end
          3'd1: begin
            arg[7:0] <= shift_q;
            byte_idx <= 3'd2;
          end
          3'd2: begin
            arg[15:8] <= shift_q;
            byte_idx  <= 3'd3;
          end
          3'd3: begin
            arg[23:16] <= shift_q;
            byte_idx   <= 3'd4;
          end
          default: begin
            cmd.op      <= hold_op;
            cmd.data    <= {shift_q, arg};
            cmd.execute <= 1'b1;
            byte_idx    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed scoreboard bench for uart_cmd_receiver.
// FREQ=4, RATE=1 so one bit is four clocks with trxClock tied high.
module tb_uart_cmd_receiver;

  localparam int BP = 4;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
    logic        xon;
    logic        xoff;
    logic        id;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trxClock = 1'b1;
  logic rx = 1'b1;

  uart_cmd_receiver_if cmd ();

  uart_cmd_receiver #(
    .FREQ (4),
    .RATE (1),
    .CNT_W(16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .trxClock(trxClock),
    .rx      (rx),
    .cmd     (cmd)
  );

  always #5 clock = ~clock;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int exec_n = 0;
  int ferr_n = 0;
  logic prev_exec = 1'b0;
  logic prev_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (cmd.execute) begin
        exec_n++;
        if (q.size() == 0) begin
          chk("unexpected_execute", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("op", {24'd0, cmd.op}, {24'd0, e.op});
          chk("data", cmd.data, e.data);
          chk("xon", {31'd0, cmd.xon}, {31'd0, e.xon});
          chk("xoff", {31'd0, cmd.xoff}, {31'd0, e.xoff});
          chk("id", {31'd0, cmd.id}, {31'd0, e.id});
        end
      end else begin
        chk("stray_pulse", {29'd0, cmd.xon, cmd.xoff, cmd.id}, 32'd0);
      end
      chk("exec_width", {31'd0, prev_exec & cmd.execute}, 32'd0);
      chk("ferr_width", {31'd0, prev_ferr & cmd.frame_err}, 32'd0);
      if (cmd.frame_err) ferr_n++;
      prev_exec = cmd.execute;
      prev_ferr = cmd.frame_err;
    end else begin
      prev_exec = 1'b0;
      prev_ferr = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cycles(BP);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] op, input logic [31:0] data,
                      input logic xon, input logic xoff, input logic id);
    exp_t e;
    e.op = op;
    e.data = data;
    e.xon = xon;
    e.xoff = xoff;
    e.id = id;
    q.push_back(e);
  endtask

  int e0;
  int f0;

  initial begin
    cycles(3);
    chk("rst_op", {24'd0, cmd.op}, 32'd0);
    chk("rst_data", cmd.data, 32'd0);
    chk("rst_exec", {31'd0, cmd.execute}, 32'd0);
    chk("rst_pulses", {28'd0, cmd.xon, cmd.xoff, cmd.id, cmd.frame_err}, 32'd0);
    reset = 1'b0;
    cycles(5);

    // short xon command
    e0 = exec_n;
    push(8'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1);
    cycles(12);
    chk("xon_exec_count", exec_n - e0, 32'd1);
    chk("xon_drained", q.size(), 32'd0);
    chk("xon_no_ferr", ferr_n, 32'd0);

    // long command, back-to-back bytes
    e0 = exec_n;
    push(8'h80, 32'h12345678, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("long_no_early_exec", exec_n - e0, 32'd0);
    send_byte(8'h12, 1'b1);
    cycles(12);
    chk("long_exec_count", exec_n - e0, 32'd1);
    chk("long_drained", q.size(), 32'd0);
    chk("long_hold_op", {24'd0, cmd.op}, 32'h80);
    chk("long_hold_data", cmd.data, 32'h12345678);

    // one-cycle glitch on rx
    e0 = exec_n;
    f0 = ferr_n;
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(30);
    chk("glitch_no_exec", exec_n - e0, 32'd0);
    chk("glitch_no_ferr", ferr_n - f0, 32'd0);

    // framing error then xoff
    e0 = exec_n;
    f0 = ferr_n;
    send_byte(8'h55, 1'b0);
    cycles(12);
    chk("ferr_count", ferr_n - f0, 32'd1);
    chk("ferr_no_exec", exec_n - e0, 32'd0);
    push(8'h13, 32'd0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h13, 1'b1);
    cycles(12);
    chk("xoff_exec_count", exec_n - e0, 32'd1);
    chk("xoff_drained", q.size(), 32'd0);

    // reset in the middle of a long command
    send_byte(8'h81, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    rx = 1'b1;
    cycles(3);
    chk("midrst_op", {24'd0, cmd.op}, 32'd0);
    chk("midrst_data", cmd.data, 32'd0);
    reset = 1'b0;
    cycles(5);
    e0 = exec_n;
    push(8'h02, 32'd0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h02, 1'b1);
    cycles(12);
    chk("id_exec_count", exec_n - e0, 32'd1);
    chk("id_drained", q.size(), 32'd0);

    // long command whose argument bytes look like xon/xoff/id
    e0 = exec_n;
    push(8'h82, 32'h00021311, 1'b0, 1'b0, 1'b0);
    send_byte(8'h82, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(12);
    chk("arg_exec_count", exec_n - e0, 32'd1);
    chk("arg_drained", q.size(), 32'd0);
    chk("final_ferr_total", ferr_n, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_receiver.md
Name: uart_cmd_receiver

Overview:
- Serial receive stage of the analyzer's host link. It sits in front of the command decoder and alongside the sample transmitter.
- Deserialises 8N1 UART frames, LSB first, using the same trxClock tick enable and FREQ/RATE bit timing as the transmit side.
- Assembles 1-byte short commands and 5-byte long commands (opcode plus 32-bit argument) and issues a one-cycle execute strobe for each.
- Decodes the flow-control and ID opcodes directly into the xon, xoff and id pulses the transmitter consumes.

Parameters:
- FREQ, 100000000, system clock frequency in Hz.
- RATE, 115200, baud rate. BITLENGTH = FREQ/RATE counts of trxClock ticks per bit.
- CNT_W, 16, bit-counter width. BITLENGTH must be < 2^CNT_W.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- trxClock  in  1  baud tick enable; counters advance only on cycles where it is 1
- rx  in  1  serial input, idle high, asynchronous to clock
- op  out  8  opcode of the last executed command
- data  out  32  argument of the last executed command (0 for short commands)
- execute  out  1  one-cycle strobe: op/data valid
- xon  out  1  one-cycle pulse, opcode 0x11
- xoff  out  1  one-cycle pulse, opcode 0x13
- id  out  1  one-cycle pulse, opcode 0x02
- frame_err  out  1  one-cycle pulse, bad stop bit

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values: op=0, data=0, execute=0, xon=0, xoff=0, id=0, frame_err=0. The rx synchroniser flops reset to 1. FSM goes to IDLE. Byte index and assembly buffer clear.
- Reset mid-frame or mid-command aborts everything. No strobe is issued for the partial frame.
- Synchroniser: rx passes through 2 flops (rxs). All decisions use rxs.
- Bit counter: increments on trxClock cycles and clears when it reaches its target.
- FSM states and transitions:
  - IDLE: when rxs==0, go to START with counter=0.
  - START: when counter==BITLENGTH/2 (integer division), sample rxs.
    - If rxs==1, treat as a glitch and return to IDLE silently.
    - Otherwise go to DATA with bit index=0 and counter=0.
  - DATA: each time counter==BITLENGTH, shift rxs into shift[7] (shift right, LSB first) and increment the bit index.
    - After the 8th sample, go to STOP.
  - STOP: when counter==BITLENGTH, sample rxs.
    - If rxs==1, the byte is valid; go to IDLE.
    - If rxs==0, pulse frame_err, discard the byte, clear command assembly, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a held break from retriggering.
- Resulting timing: mid-bit sampling. Byte valid about 9.5 bit times after the start edge, plus 2 synchroniser cycles.
- Command assembly (byte_idx 0..4, on each valid byte):
  - byte_idx==0 and byte[7]==0 (short command): op<=byte, data<=0, execute=1 on the next cycle, byte_idx stays 0.
  - byte_idx==0 and byte[7]==1 (long command): latch the opcode in a holding register, byte_idx=1.
  - byte_idx 1..4: the byte fills argument bits [8*(idx-1)+7 : 8*(idx-1)], so the first argument byte is the LSB.
  - On the 4th argument byte: op and data update together, execute pulses, byte_idx returns to 0.
- Output hold: op and data hold their values between execute strobes. They are never partially updated.
- Pulse decode: xon, xoff and id pulse in the same cycle as execute, only for short commands 0x11, 0x13 and 0x02.
  - A long command whose argument bytes equal 0x11 or 0x13 generates no xon/xoff.
- Pulse width: all strobes are exactly 1 clock wide, including when trxClock is tied high.
- Back-to-back frames: a start bit detected on the same cycle as IDLE entry from STOP is accepted. There is no dead cycle requirement beyond the stop-bit sample.

Test Plan:
- FREQ=4, RATE=1, trxClock=1. Send 0x11 → exactly one execute with op=0x11, data=0, one xon pulse, xoff=0, frame_err=0.
- Send 0x80,0x78,0x56,0x34,0x12 back-to-back → single execute after the 5th byte: op=0x80, data=0x12345678. No strobe after bytes 1–4.
- Drive rx low for 1 cycle only (shorter than half a bit) → returns to IDLE, no execute, no frame_err.
- Send 0x55 with stop bit forced 0 → frame_err pulse, no execute. Then send 0x13 → op=0x13, xoff pulse.
- Send 0x81,0xAA, assert reset mid third byte, release, then send 0x02 → op=0x02, data=0, id pulse. The aborted long command never executes.
- Send 0x82 then argument bytes 0x11,0x13,0x02,0x00 → execute with op=0x82, data=0x00021311. No xon/xoff/id pulse.
